// File: rtl/tc_sram_hs.sv
// tc_sram_hs: multi-port SRAM; each port has a read pipeline and an in-order response FIFO.
// Latency: read grant to earliest rvalid_o is Latency cycles; writes take effect at the grant edge.
// Backpressure: a port stops granting reads once RespDepth responses are owed. Macro: TC_SRAM_HS_WRITE_BYPASS_EN.
module tc_sram_hs #(
    parameter int NumWords   = 1024,
    parameter int DataWidth  = 64,
    parameter int ByteWidth  = 8,
    parameter int NumPorts   = 2,
    parameter int Latency    = 1,
    parameter int RespDepth  = 2,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumPorts-1:0]                req_i,
    output logic [NumPorts-1:0]                gnt_o,
    input  logic [NumPorts-1:0]                we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]   be_i,
    output logic [NumPorts-1:0]                rvalid_o,
    input  logic [NumPorts-1:0]                rready_i,
    output logic [NumPorts-1:0][DataWidth-1:0] rdata_o
);
    localparam int CntWidth = $clog2(RespDepth + 1);
    localparam int PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    logic [DataWidth-1:0] mem [NumWords];

    logic [NumPorts-1:0]                in_range;
    logic [NumPorts-1:0]                wr_gnt;
    logic [NumPorts-1:0]                rd_gnt;
    logic [NumPorts-1:0]                pop;
    logic [NumPorts-1:0]                cnt_ok;
    logic [NumPorts-1:0][DataWidth-1:0] wmask;
    logic [NumPorts-1:0][DataWidth-1:0] rd_word;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(RespDepth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            in_range[p] = 32'(addr_i[p]) < 32'(NumWords);
            for (int b = 0; b < DataWidth; b++) begin
                wmask[p][b] = be_i[p][b / ByteWidth];
            end
            wr_gnt[p] = !rst_i && req_i[p] && we_i[p];
            // A pop in the same cycle frees a slot, so a full port can still keep streaming.
            rd_gnt[p] = !rst_i && req_i[p] && !we_i[p] && (cnt_ok[p] || pop[p]);
        end
    end

    assign gnt_o = wr_gnt | rd_gnt;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            rd_word[p] = '0;
            if (in_range[p]) begin
                rd_word[p] = mem[addr_i[p]];
`ifdef TC_SRAM_HS_WRITE_BYPASS_EN
                for (int q = 0; q < NumPorts; q++) begin
                    if (wr_gnt[q] && in_range[q] && (addr_i[q] == addr_i[p])) begin
                        rd_word[p] = (rd_word[p] & ~wmask[q]) | (wdata_i[q] & wmask[q]);
                    end
                end
`endif
            end
        end
    end

    // Ascending port order with per-bit updates: the highest enabled port wins each byte.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumPorts; p++) begin
            if (wr_gnt[p] && in_range[p]) begin
                for (int b = 0; b < DataWidth; b++) begin
                    if (wmask[p][b]) begin
                        mem[addr_i[p]][b] <= wdata_i[p][b];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NumPorts; g++) begin : g_port
        logic [CntWidth-1:0]  outstanding;
        logic [CntWidth-1:0]  fill;
        logic [PtrWidth-1:0]  wptr;
        logic [PtrWidth-1:0]  rptr;
        logic [DataWidth-1:0] fifo_mem [RespDepth];
        logic                 pipe_vld;
        logic [DataWidth-1:0] pipe_dat;

        if (Latency > 1) begin : g_pipe
            logic [Latency-2:0]   stg_vld;
            logic [DataWidth-1:0] stg_dat [Latency-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    stg_vld <= '0;
                end else begin
                    stg_vld[0] <= rd_gnt[g];
                    for (int s = 1; s < Latency - 1; s++) begin
                        stg_vld[s] <= stg_vld[s-1];
                    end
                end
                stg_dat[0] <= rd_word[g];
                for (int s = 1; s < Latency - 1; s++) begin
                    stg_dat[s] <= stg_dat[s-1];
                end
            end

            assign pipe_vld = stg_vld[Latency-2];
            assign pipe_dat = stg_dat[Latency-2];
        end else begin : g_nopipe
            assign pipe_vld = rd_gnt[g];
            assign pipe_dat = rd_word[g];
        end

        assign rvalid_o[g] = !rst_i && (fill != '0);
        assign rdata_o[g]  = rvalid_o[g] ? fifo_mem[rptr] : '0;
        assign pop[g]      = rvalid_o[g] && rready_i[g];
        assign cnt_ok[g]   = outstanding < CntWidth'(RespDepth);

        // outstanding covers both pipeline and FIFO, so the FIFO can never overflow.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                outstanding <= '0;
                fill        <= '0;
                wptr        <= '0;
                rptr        <= '0;
            end else begin
                if (rd_gnt[g] && !pop[g]) begin
                    outstanding <= outstanding + CntWidth'(1);
                end else if (!rd_gnt[g] && pop[g]) begin
                    outstanding <= outstanding - CntWidth'(1);
                end
                if (pipe_vld && !pop[g]) begin
                    fill <= fill + CntWidth'(1);
                end else if (!pipe_vld && pop[g]) begin
                    fill <= fill - CntWidth'(1);
                end
                if (pipe_vld) begin
                    wptr <= ptr_inc(wptr);
                end
                if (pop[g]) begin
                    rptr <= ptr_inc(rptr);
                end
            end
            if (pipe_vld && !rst_i) begin
                fifo_mem[wptr] <= pipe_dat;
            end
        end
    end

endmodule
